// File: rtl/npu_result_drain_if.sv
// Result stream from the drain stage to the result sink.
// Pure wiring, no latency.
// Sink throttles the stream with out_ready; the source holds the word until it is accepted.
interface npu_result_drain_if #(
    parameter int DATA_W = 32,
    parameter int N      = 3
);
    localparam int IDX_W = (N * N > 1) ? $clog2(N * N) : 1;

    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output out_data,
        output out_idx,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_idx,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/npu_result_drain.sv
// Snapshots the N*N accumulator words on a rising edge of done and streams them out in row-major order.
// Word 0 is presented the cycle after the trigger edge; one word per cycle while out_ready is high.
// out_ready low holds word/index/last stable; a trigger while draining is dropped and sets the sticky ovf flag.
module npu_result_drain #(
    parameter int DATA_W  = 32,
    parameter int N       = 3,
    parameter int RELU_EN = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    done_i,
    input  logic [DATA_W*N*N-1:0]   c_flat_i,
    input  logic                    ovf_clr_i,
    output logic                    busy_o,
    output logic                    drain_done_o,
    output logic                    ovf_o,
    npu_result_drain_if.master      out_if
);
    localparam int NW    = N * N;
    localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              done_q;
    logic              ovf_q, ovf_d;
    logic              drain_done_q, drain_done_d;
    logic              load;
    logic [DATA_W-1:0] buf_q [NW];

    logic              trig;
    logic              xfer;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] out_word;

    assign trig = done_i && !done_q;
    assign xfer = (state_q == DRAIN) && out_if.out_ready;

    // Next-state, index advance, capture strobe and flag updates.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        load         = 1'b0;
        drain_done_d = 1'b0;
        ovf_d        = ovf_q;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = DRAIN;
                    idx_d   = '0;
                    load    = 1'b1;
                end
            end
            DRAIN: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        state_d      = IDLE;
                        idx_d        = '0;
                        drain_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
        // Clear first so that an overflowing trigger on the same edge wins.
        if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
        if (trig && (state_q == DRAIN)) begin
            ovf_d = 1'b1;
        end
    end

    // Control registers: state, read index, done edge history, flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
            drain_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            done_q       <= done_i;
            ovf_q        <= ovf_d;
            drain_done_q <= drain_done_d;
        end
    end

    // Snapshot buffer: loaded only on an accepted trigger so the array may keep changing afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NW; k++) begin
                buf_q[k] <= '0;
            end
        end else if (load) begin
            for (int k = 0; k < NW; k++) begin
                buf_q[k] <= c_flat_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign rd_word  = buf_q[idx_q];
    assign out_word = ((RELU_EN != 0) && rd_word[DATA_W-1]) ? '0 : rd_word;

    // Outputs are forced to zero outside DRAIN so the idle bus never shows stale data.
    assign out_if.out_valid = (state_q == DRAIN);
    assign out_if.out_data  = (state_q == DRAIN) ? out_word : '0;
    assign out_if.out_idx   = (state_q == DRAIN) ? idx_q : '0;
    assign out_if.out_last  = (state_q == DRAIN) && (idx_q == LAST_IDX);

    assign busy_o       = (state_q == DRAIN);
    assign drain_done_o = drain_done_q;
    assign ovf_o        = ovf_q;
endmodule
